// File: rtl/tag_tree_dec.sv
// tag_tree_dec
//   Decodes one 3-level zero-bitplane tag tree (1 root, 2x2 mid, 4x4 leaves)
//   from a packet-header byte stream and emits the 16 leaf values in raster
//   order. The byte stream carries JPEG2000 bit-stuffing: after a 0xFF byte
//   the MSB of the next byte is a stuffed bit and is discarded.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axis_hdr_rx_*            header byte input (valid/ready/last/data)
//   m_axis_zero_tx_*           leaf value output (valid/ready/last/data)
//   err_o                      sticky errors: [0] value overflow,
//                              [1] tree needed a byte after a last byte
module tag_tree_dec #(
  parameter int ZERO_DATA_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_axis_hdr_rx_valid_i,
  input  logic                   s_axis_hdr_rx_last_i,
  input  logic [7:0]             s_axis_hdr_rx_data_i,
  output logic                   s_axis_hdr_rx_ready_o,
  output logic                   m_axis_zero_tx_valid_o,
  output logic                   m_axis_zero_tx_last_o,
  output logic [ZERO_DATA_W-1:0] m_axis_zero_tx_data_o,
  input  logic                   m_axis_zero_tx_ready_i,
  output logic [1:0]             err_o
);

  localparam int NODES = 21;  // node 0 root, 1..4 mid, 5..20 leaves
  localparam logic [ZERO_DATA_W-1:0] VAL_MAX = '1;
  localparam logic [ZERO_DATA_W-1:0] VAL_ONE = ZERO_DATA_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_WALK, S_FETCH, S_EMIT, S_ALIGN} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             lvl_reg, lvl_next;
  logic [ZERO_DATA_W-1:0] floor_reg, floor_next;
  logic [3:0]             idx_reg, idx_next;
  logic [7:0]             byte_reg, byte_next;
  logic [3:0]             cnt_reg, cnt_next;     // undecoded bits left in byte_reg
  logic                   stuff_reg, stuff_next; // last loaded byte was 0xFF
  logic                   last_reg, last_next;   // last loaded byte carried last_i
  logic [1:0]             err_reg, err_next;

  logic [ZERO_DATA_W-1:0] node_val_reg [NODES];
  logic [NODES-1:0]       node_known_reg;

  logic                   node_clear;
  logic                   node_we;
  logic [ZERO_DATA_W-1:0] node_wval;
  logic                   node_wknown;
  logic [4:0]             node_sel;
  logic [4:0]             leaf_sel;
  logic [ZERO_DATA_W-1:0] cur_val;
  logic [ZERO_DATA_W-1:0] eff_val;
  logic                   cur_known;
  logic [2:0]             bit_pos;
  logic                   cur_bit;

  // Node covering the current leaf at the current level. Mid index is
  // (y>>1)*2 + (x>>1) = {idx[3], idx[1]}; leaf index is the raster index.
  always_comb begin
    node_sel = 5'd0;
    case (lvl_reg)
      2'd0:    node_sel = 5'd0;
      2'd1:    node_sel = 5'd1 + {3'b000, idx_reg[3], idx_reg[1]};
      default: node_sel = 5'd5 + {1'b0, idx_reg};
    endcase
  end

  assign leaf_sel  = 5'd5 + {1'b0, idx_reg};
  assign cur_val   = node_val_reg[node_sel];
  assign cur_known = node_known_reg[node_sel];
  assign eff_val   = (cur_val > floor_reg) ? cur_val : floor_reg;
  // Bits are taken MSB first; a count of 8 wraps to position 7.
  assign bit_pos   = cnt_reg[2:0] - 3'd1;
  assign cur_bit   = byte_reg[bit_pos];

  always_comb begin
    state_next  = state_reg;
    lvl_next    = lvl_reg;
    floor_next  = floor_reg;
    idx_next    = idx_reg;
    byte_next   = byte_reg;
    cnt_next    = cnt_reg;
    stuff_next  = stuff_reg;
    last_next   = last_reg;
    err_next    = err_reg;
    node_clear  = 1'b0;
    node_we     = 1'b0;
    node_wval   = eff_val;
    node_wknown = 1'b0;

    case (state_reg)
      S_IDLE: begin
        node_clear = 1'b1;
        lvl_next   = 2'd0;
        floor_next = '0;
        idx_next   = 4'd0;
        state_next = S_WALK;
      end

      S_WALK: begin
        if (cur_known) begin
          floor_next = cur_val;
          if (lvl_reg == 2'd2) state_next = S_EMIT;
          else                 lvl_next   = lvl_reg + 2'd1;
        end else if (cnt_reg != 4'd0) begin
          cnt_next = cnt_reg - 4'd1;
          node_we  = 1'b1;
          if (cur_bit) begin
            node_wknown = 1'b1;
          end else if (eff_val == VAL_MAX) begin
            err_next[0] = 1'b1;  // saturate, keep decoding
          end else begin
            node_wval = eff_val + VAL_ONE;
          end
        end else begin
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        if (s_axis_hdr_rx_valid_i) begin
          byte_next  = s_axis_hdr_rx_data_i;
          cnt_next   = stuff_reg ? 4'd7 : 4'd8;
          stuff_next = (s_axis_hdr_rx_data_i == 8'hFF);
          last_next  = s_axis_hdr_rx_last_i;
          if (last_reg) err_next[1] = 1'b1;  // segment already ended
          state_next = S_WALK;
        end
      end

      S_EMIT: begin
        if (m_axis_zero_tx_ready_i) begin
          idx_next   = idx_reg + 4'd1;
          lvl_next   = 2'd0;
          floor_next = '0;
          state_next = (idx_reg == 4'd15) ? S_ALIGN : S_WALK;
        end
      end

      S_ALIGN: begin
        // Each tree is byte aligned; the stuff flag survives so the next
        // tree's first byte is unstuffed if this tree ended on 0xFF.
        cnt_next   = 4'd0;
        last_next  = 1'b0;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      lvl_reg   <= 2'd0;
      floor_reg <= '0;
      idx_reg   <= 4'd0;
      byte_reg  <= 8'd0;
      cnt_reg   <= 4'd0;
      stuff_reg <= 1'b0;
      last_reg  <= 1'b0;
      err_reg   <= 2'b00;
    end else begin
      state_reg <= state_next;
      lvl_reg   <= lvl_next;
      floor_reg <= floor_next;
      idx_reg   <= idx_next;
      byte_reg  <= byte_next;
      cnt_reg   <= cnt_next;
      stuff_reg <= stuff_next;
      last_reg  <= last_next;
      err_reg   <= err_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NODES; gi++) begin : g_node
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          node_val_reg[gi]   <= '0;
          node_known_reg[gi] <= 1'b0;
        end else if (node_clear) begin
          node_val_reg[gi]   <= '0;
          node_known_reg[gi] <= 1'b0;
        end else if (node_we && (node_sel == 5'(gi))) begin
          node_val_reg[gi]   <= node_wval;
          node_known_reg[gi] <= node_wknown;
        end
      end
    end
  endgenerate

  // Outputs decode the state register only, so they drop to 0 with reset.
  assign s_axis_hdr_rx_ready_o  = (state_reg == S_FETCH);
  assign m_axis_zero_tx_valid_o = (state_reg == S_EMIT);
  assign m_axis_zero_tx_last_o  = (state_reg == S_EMIT) && (idx_reg == 4'd15);
  assign m_axis_zero_tx_data_o  = (state_reg == S_EMIT) ? node_val_reg[leaf_sel] : '0;
  assign err_o                  = err_reg;

endmodule

// File: tb/tb_tag_tree_dec.sv
// tb_tag_tree_dec
//   Randomized and directed bench for tag_tree_dec. Trees are produced by a
//   tag-tree encoder model (node values -> bit string -> stuffed bytes);
//   expected leaves are queued at stimulus time and popped by a monitor.
module tb_tag_tree_dec;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hdr_valid, hdr_last, hdr_ready;
  logic [7:0]   hdr_data;
  logic         z_valid, z_last, z_ready;
  logic [W-1:0] z_data;
  logic [1:0]   err;

  always #5 clk = ~clk;

  tag_tree_dec #(.ZERO_DATA_W(W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_hdr_rx_valid_i  (hdr_valid),
    .s_axis_hdr_rx_last_i   (hdr_last),
    .s_axis_hdr_rx_data_i   (hdr_data),
    .s_axis_hdr_rx_ready_o  (hdr_ready),
    .m_axis_zero_tx_valid_o (z_valid),
    .m_axis_zero_tx_last_o  (z_last),
    .m_axis_zero_tx_data_o  (z_data),
    .m_axis_zero_tx_ready_i (z_ready),
    .err_o                  (err)
  );

  typedef struct packed { logic [7:0] data; logic last; } byte_t;
  typedef struct packed { logic [W-1:0] val; logic last; } leaf_t;

  byte_t in_q[$];
  leaf_t exp_q[$];
  byte_t drv_b;
  int    checks = 0;
  int    errors = 0;
  int    leaf_cnt = 0;
  int    bytes_acc = 0;
  int    rdy_mode = 0;   // 0 always ready, 1 random, 2 stall at leaf 4
  bit    bp_done = 1'b0;
  bit    gaps_en = 1'b0;
  bit    abort_drv = 1'b0;
  bit    prev_ff = 1'b0; // model: last byte sent was 0xFF

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- model helpers ----------------
  task automatic push_bytes(input logic [7:0] b [$]);
    byte_t e;
    for (int i = 0; i < b.size(); i++) begin
      e.data = b[i];
      e.last = (i == b.size() - 1);
      in_q.push_back(e);
    end
    prev_ff = (b[b.size()-1] == 8'hFF);
  endtask

  task automatic push_leaves(input int v [16]);
    leaf_t l;
    for (int i = 0; i < 16; i++) begin
      l.val  = W'(v[i]);
      l.last = (i == 15);
      exp_q.push_back(l);
    end
  endtask

  task automatic push_const_tree(input logic [7:0] b [$], input int v);
    int vals [16];
    for (int i = 0; i < 16; i++) vals[i] = v;
    push_bytes(b);
    push_leaves(vals);
  endtask

  // Tag-tree encoder: on first visit a node sends (value - floor) zeros
  // then a one; packing honours 0xFF stuffing across tree boundaries.
  task automatic gen_tree();
    int   root, mid [4], leaf [16], fl, v, id, pos, cap;
    bit   done [21];
    bit   bits [$];
    logic [7:0] bq [$];
    logic [7:0] b;
    root = $urandom_range(0, 5);
    for (int m = 0; m < 4; m++) mid[m] = root + $urandom_range(0, 3);
    for (int i = 0; i < 16; i++) leaf[i] = mid[(i / 8) * 2 + (i % 4) / 2] + $urandom_range(0, 3);
    for (int i = 0; i < 21; i++) done[i] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      fl = 0;
      for (int lvl = 0; lvl < 3; lvl++) begin
        if (lvl == 0) begin id = 0; v = root; end
        else if (lvl == 1) begin id = 1 + (i / 8) * 2 + (i % 4) / 2; v = mid[id-1]; end
        else begin id = 5 + i; v = leaf[i]; end
        if (!done[id]) begin
          for (int k = 0; k < v - fl; k++) bits.push_back(1'b0);
          bits.push_back(1'b1);
          done[id] = 1'b1;
        end
        fl = v;
      end
    end
    pos = 0;
    while (pos < bits.size()) begin
      cap = prev_ff ? 7 : 8;
      b = 8'd0;
      for (int k = 0; k < cap; k++) begin
        b = {b[6:0], (pos < bits.size()) ? bits[pos] : 1'b0};
        pos++;
      end
      bq.push_back(b);
      prev_ff = (b == 8'hFF);
    end
    push_bytes(bq);
    push_leaves(leaf);
  endtask

  // ---------------- drivers / monitor ----------------
  initial begin
    int n;
    hdr_valid = 1'b0; hdr_last = 1'b0; hdr_data = 8'd0;
    forever begin
      if (!rst_n || abort_drv || in_q.size() == 0) begin
        hdr_valid = 1'b0;
        @(posedge clk); #1;
      end else if (gaps_en && $urandom_range(0, 3) == 0) begin
        hdr_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        drv_b = in_q.pop_front();
        hdr_valid = 1'b1;
        hdr_data  = drv_b.data;
        hdr_last  = drv_b.last;
        n = 0;
        forever begin
          @(negedge clk);
          if (abort_drv) break;
          if (hdr_ready) begin @(posedge clk); #1; break; end
          n++;
          if (n > 2000) begin
            checks++; errors++;
            $display("FAIL byte_accept_timeout: byte %0h never accepted", drv_b.data);
            break;
          end
        end
        hdr_valid = 1'b0;
      end
    end
  end

  initial begin
    logic [W-1:0] cap;
    z_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: z_ready = 1'b1;
        1: z_ready = ($urandom_range(0, 3) != 0);
        default: begin
          z_ready = 1'b1;
          if (!bp_done && z_valid && (leaf_cnt % 16) == 4) begin
            z_ready = 1'b0;
            cap = z_data;
            repeat (5) begin
              @(negedge clk);
              check("bp_valid", 32'(z_valid), 32'd1);
              check("bp_data", 32'(z_data), 32'(cap));
              check("bp_hdr_ready", 32'(hdr_ready), 32'd0);
            end
            bp_done = 1'b1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n && hdr_valid && hdr_ready) bytes_acc++;
    if (rst_n && z_valid && z_ready) begin
      $display("leaf %0d data %0d last %0d", leaf_cnt % 16, z_data, z_last);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_leaf: got data %0d with nothing expected", z_data);
      end else begin
        leaf_t e;
        e = exp_q.pop_front();
        check("leaf_data", 32'(z_data), 32'(e.val));
        check("leaf_last", 32'(z_last), 32'(e.last));
      end
      leaf_cnt++;
    end
  end

  // ---------------- sequencing ----------------
  task automatic do_reset();
    abort_drv = 1'b1;
    rst_n = 1'b0;
    in_q.delete();
    exp_q.delete();
    prev_ff = 1'b0;
    repeat (3) @(posedge clk);
    leaf_cnt = 0;
    #1 rst_n = 1'b1;
    abort_drv = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("tree_done_in_time", 32'(n < 20000), 32'd1);
    repeat (6) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(z_valid), 32'd0);
    check({tag, "_last"}, 32'(z_last), 32'd0);
    check({tag, "_data"}, 32'(z_data), 32'd0);
    check({tag, "_hdr_ready"}, 32'(hdr_ready), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    int b0, n;
    #2;
    check_idle_outputs("reset");
    do_reset();

    // all-zero tree
    rdy_mode = 0;
    b0 = bytes_acc;
    push_const_tree('{8'hFF, 8'h7F, 8'hFC}, 0);
    wait_done();
    check("zero_tree_bytes", 32'(bytes_acc - b0), 32'd3);
    check("zero_tree_err", 32'(err), 32'd0);

    // root 3, all leaves 3
    b0 = bytes_acc;
    push_const_tree('{8'h1F, 8'hFF, 8'h7F, 8'h80}, 3);
    wait_done();
    check("three_tree_bytes", 32'(bytes_acc - b0), 32'd4);

    // backpressure at leaf 4
    rdy_mode = 2;
    bp_done = 1'b0;
    push_const_tree('{8'h1F, 8'hFF, 8'h7F, 8'h80}, 3);
    wait_done();
    check("bp_exercised", 32'(bp_done), 32'd1);

    // random trees, random gaps and backpressure
    rdy_mode = 1;
    gaps_en = 1'b1;
    for (int t = 0; t < 20; t++) gen_tree();
    wait_done();
    check("random_err", 32'(err), 32'd0);
    gaps_en = 1'b0;
    rdy_mode = 0;

    // overflow: 32 zero bits then the ones that finish the tree
    do_reset();
    push_const_tree('{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h7F, 8'hFC}, 31);
    wait_done();
    check("overflow_err", 32'(err), 32'd1);

    // premature last: FF flagged last, tree continues into more bytes
    do_reset();
    begin
      byte_t e;
      e.data = 8'hFF; e.last = 1'b1; in_q.push_back(e);
      e.data = 8'hFF; e.last = 1'b0; in_q.push_back(e);
      e.data = 8'h7E; e.last = 1'b1; in_q.push_back(e);
      for (int i = 0; i < 16; i++) begin
        leaf_t l;
        l.val = '0; l.last = (i == 15);
        exp_q.push_back(l);
      end
    end
    wait_done();
    check("premature_last_err", 32'(err), 32'd2);

    // reset mid-tree at leaf 6, then a clean tree
    do_reset();
    push_const_tree('{8'hFF, 8'h7F, 8'hFC}, 0);
    n = 0;
    while (leaf_cnt < 6 && n < 2000) begin @(posedge clk); n++; end
    check("reached_leaf6", 32'(leaf_cnt >= 6), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    do_reset();
    push_const_tree('{8'hFF, 8'h7F, 8'hFC}, 0);
    wait_done();
    check("after_reset_err", 32'(err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
